// File: rtl/disp_scan.sv
// Multiplexed hex display scanner: free-running digit sequencing, leading-zero
// blanking, per-slot dead time, and frame-boundary deferral of new data.
module disp_scan #(
   parameter int DIGITS    = 4,
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  blank_lz,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  blank,
   output logic                  pending
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0]    pend_q, pend_d;
   logic [4*DIGITS-1:0]    disp_q, disp_d;
   logic                   pending_q, pending_d;
   logic [3:0]             nibble_q, nibble_d;
   logic [DIGITS-1:0]      en_q, en_d;
   logic                   blank_q, blank_d;

   logic                   last_slot, frame_end, dead;
   logic [DIGITS-1:0]      lz;

   generate
      if (BLANK_CYC == 0) begin : g_no_dead
         assign dead = 1'b0;
      end else begin : g_dead
         localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYC);
         assign dead = (cnt_q < BLANK_W);
      end
   endgenerate

   always_comb begin
      last_slot = (cnt_q == CNT_MAX);
      frame_end = last_slot && (idx_q == IDX_MAX);
      cnt_d     = last_slot ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (last_slot) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
   end

   // A load on the frame-end cycle bypasses pend_q and goes straight to display.
   always_comb begin
      pend_d    = pend_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      if (load) begin
         pend_d = data;
         if (frame_end) begin
            disp_d    = data;
            pending_d = 1'b0;
         end else begin
            pending_d = 1'b1;
         end
      end else if (frame_end && pending_q) begin
         disp_d    = pend_q;
         pending_d = 1'b0;
      end
   end

   // Walk down from the top digit; a digit is blanked while every nibble above
   // and including it is zero. Digit 0 is never blanked.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz       = '0;
      for (int unsigned k = 0; k < DIGITS - 1; k++) begin
         zero_run = zero_run & (disp_q[4*(DIGITS-1-k) +: 4] == 4'h0);
         lz[DIGITS-1-k] = zero_run & blank_lz;
      end
   end

   always_comb begin
      nibble_d = disp_q[{idx_q, 2'b00} +: 4];
      blank_d  = lz[idx_q];
      en_d     = '1;
      if (!dead && !lz[idx_q]) begin
         en_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         pend_q    <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         nibble_q  <= '0;
         blank_q   <= 1'b0;
         en_q      <= '1;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pend_q    <= pend_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         nibble_q  <= nibble_d;
         blank_q   <= blank_d;
         en_q      <= en_d;
      end
   end

   assign nibble   = nibble_q;
   assign digit_en = en_q;
   assign blank    = blank_q;
   assign pending  = pending_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIGITS=4, DIV=4, BLANK_CYC=1.
module tb_disp_scan;

   localparam int DIGITS    = 4;
   localparam int DIV       = 4;
   localparam int BLANK_CYC = 1;

   logic        clk = 1'b0;
   logic        rst, load, blank_lz;
   logic [15:0] data;
   logic [3:0]  nibble, digit_en;
   logic        blank, pending;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   disp_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .data     (data),
      .blank_lz (blank_lz),
      .nibble   (nibble),
      .digit_en (digit_en),
      .blank    (blank),
      .pending  (pending)
   );

   // One record per digit slot; load (if any) is applied on the slot's first cycle.
   // en is the enable pattern after the dead cycle; pend_last is pending after the slot's last edge.
   typedef struct {
      logic        ld;
      logic [15:0] d;
      logic        blz;
      logic [3:0]  nib;
      logic [3:0]  en;
      logic        blk;
      logic        pend;
      logic        pend_last;
   } slot_vec_t;

   slot_vec_t   vecs[28];
   logic [3:0]  en_act[4];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      en_act[0] = 4'b1110; en_act[1] = 4'b1101; en_act[2] = 4'b1011; en_act[3] = 4'b0111;

      // frame 0: free-running scan, nothing loaded
      vecs[0]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1101, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1011, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b0, 1'b0};
      // frame 1: mid-frame load of 1A3F is deferred
      vecs[4]  = '{1'b1, 16'h1A3F, 1'b0, 4'h0, 4'b1110, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1101, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1011, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b1, 1'b0};
      // frame 2: 1A3F shown
      vecs[8]  = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 16'h0000, 1'b0, 4'h3, 4'b1101, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 16'h0000, 1'b0, 4'hA, 4'b1011, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 16'h0000, 1'b0, 4'h1, 4'b0111, 1'b0, 1'b0, 1'b0};
      // frame 3: load 0050, blank_lz=1 has no effect on 1A3F
      vecs[12] = '{1'b1, 16'h0050, 1'b1, 4'hF, 4'b1110, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 16'h0000, 1'b1, 4'h3, 4'b1101, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 16'h0000, 1'b1, 4'hA, 4'b1011, 1'b0, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 16'h0000, 1'b1, 4'h1, 4'b0111, 1'b0, 1'b1, 1'b0};
      // frame 4: 0050 with leading-zero blanking
      vecs[16] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 16'h0000, 1'b1, 4'h5, 4'b1101, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
      // frame 5: 0050 without blanking; load 0000 in the last slot
      vecs[20] = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 16'h0000, 1'b0, 4'h5, 4'b1101, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 16'h0000, 1'b0, 4'h0, 4'b1011, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{1'b1, 16'h0000, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b1, 1'b0};
      // frame 6: all-zero value, only digit 0 lit
      vecs[24] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[25] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
      vecs[26] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
      vecs[27] = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; load = 1'b0; data = 16'h0; blank_lz = 1'b0;
      repeat (3) tick();
      chk("reset nibble",   16'(nibble),   16'h0);
      chk("reset digit_en", 16'(digit_en), 16'hF);
      chk("reset blank",    16'(blank),    16'h0);
      chk("reset pending",  16'(pending),  16'h0);

      rst = 1'b0;
      for (int s = 0; s < 28; s++) begin
         for (int c = 0; c < DIV; c++) begin
            load     = vecs[s].ld && (c == 0);
            data     = vecs[s].d;
            blank_lz = vecs[s].blz;
            tick();
            load = 1'b0;
            chk($sformatf("slot%0d cyc%0d nibble", s, c), 16'(nibble), 16'(vecs[s].nib));
            chk($sformatf("slot%0d cyc%0d digit_en", s, c), 16'(digit_en),
                16'((c == 0) ? 4'hF : vecs[s].en));
            chk($sformatf("slot%0d cyc%0d blank", s, c), 16'(blank), 16'(vecs[s].blk));
            chk($sformatf("slot%0d cyc%0d pending", s, c), 16'(pending),
                16'((c == DIV - 1) ? vecs[s].pend_last : vecs[s].pend));
         end
      end

      // Frame-end collision: 1111 pending, 2222 loaded on the frame-end cycle.
      blank_lz = 1'b0;
      load = 1'b1; data = 16'h1111;
      tick();
      load = 1'b0;
      chk("coll pending set", 16'(pending), 16'h1);
      repeat (14) tick();
      chk("coll pending held", 16'(pending), 16'h1);
      chk("coll disp unchanged", 16'(nibble), 16'h0);
      load = 1'b1; data = 16'h2222;
      tick();
      load = 1'b0;
      chk("coll fe pending", 16'(pending), 16'h0);
      chk("coll fe digit_en", 16'(digit_en), 16'h7);
      chk("coll fe nibble", 16'(nibble), 16'h0);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < DIV; c++) begin
            tick();
            chk($sformatf("coll s%0d c%0d nibble", s, c), 16'(nibble), 16'h2);
            chk($sformatf("coll s%0d c%0d pending", s, c), 16'(pending), 16'h0);
            chk($sformatf("coll s%0d c%0d digit_en", s, c), 16'(digit_en),
                16'((c == 0) ? 4'hF : en_act[s]));
         end
      end

      // Reset while BEEF is pending; load during reset must be ignored.
      load = 1'b1; data = 16'hBEEF;
      tick();
      load = 1'b0;
      chk("rstp pending set", 16'(pending), 16'h1);
      repeat (2) tick();
      rst = 1'b1; load = 1'b1; data = 16'h1234;
      tick();
      chk("rstp nibble",   16'(nibble),   16'h0);
      chk("rstp digit_en", 16'(digit_en), 16'hF);
      chk("rstp blank",    16'(blank),    16'h0);
      chk("rstp pending",  16'(pending),  16'h0);
      tick();
      chk("rstp load ignored", 16'(pending), 16'h0);
      rst = 1'b0; load = 1'b0;
      for (int s = 0; s < 8; s++) begin
         for (int c = 0; c < DIV; c++) begin
            tick();
            chk($sformatf("post s%0d c%0d nibble", s, c), 16'(nibble), 16'h0);
            chk($sformatf("post s%0d c%0d pending", s, c), 16'(pending), 16'h0);
            chk($sformatf("post s%0d c%0d blank", s, c), 16'(blank), 16'h0);
            chk($sformatf("post s%0d c%0d digit_en", s, c), 16'(digit_en),
                16'((c == 0) ? 4'hF : en_act[s % 4]));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/disp_scan.md
# disp_scan

Multiplexed display scanner that sits directly upstream of the team's hex-to-7-segment decoder. It holds a DIGITS-wide hex value, sequences the common digit enables, and presents one nibble per time slot to the decoder. It also generates leading-zero blanking and anti-ghosting dead time, and defers new data to a frame boundary so a displayed value never tears mid-frame.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (≥2); digit 0 is least significant.
- DIV, 50000, clk cycles per digit slot (≥2).
- BLANK_CYC, 2, dead cycles at the start of each slot with all digits off (0 ≤ BLANK_CYC < DIV).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures data.
- data  in  4*DIGITS  hex value; nibble i = data[4i+3:4i].
- blank_lz  in  1  1 = blank leading zeros.
- nibble  out  4  hex digit for the decoder's input.
- digit_en  out  DIGITS  active-low digit enables; at most one bit low.
- blank  out  1  1 = current slot blanked; downstream forces all segments off.
- pending  out  1  1 = captured value not yet shown.

## Operation
- State: slot counter cnt (0..DIV-1, width clog2(DIV)), digit index idx (0..DIGITS-1), pend_reg, disp_reg (4*DIGITS each), pending flag.
- cnt increments every cycle and wraps DIV-1→0. On wrap, idx increments, wrapping DIGITS-1→0.
- Frame end: the cycle with cnt==DIV-1 and idx==DIGITS-1. One frame = DIGITS*DIV cycles.
- load=1 (not frame end): pend_reg←data, pending←1. A later load before frame end overwrites pend_reg; the last value wins.
- Frame end with pending=1 and load=0: disp_reg←pend_reg, pending←0.
- Frame end with load=1: disp_reg←data, pend_reg←data, pending←0 (new data takes priority).
- Frame end with pending=0 and load=0: disp_reg unchanged.
- Leading-zero rule: with blank_lz=1, digit i (i≥1) is blanked when nibbles i..DIGITS-1 of disp_reg are all zero. Digit 0 is never blanked. blank_lz is sampled live each cycle.
- Outputs are registered and computed each cycle from the pre-edge idx, cnt and disp_reg:
  - nibble = disp_reg nibble[idx].
  - blank = 1 if digit idx is lz-blanked.
  - digit_en = all ones if cnt < BLANK_CYC or the digit is blanked; otherwise bit idx is 0 and the rest are 1.
- No state machine beyond the counters; the scan is free-running and never stalls.

## Timing
- Reset values: cnt=0, idx=0, pend_reg=0, disp_reg=0, pending=0, nibble=0, blank=0, digit_en=all ones.
- Outputs lag the counters by exactly one cycle.
- The first enabled digit (digit 0) appears BLANK_CYC+1 cycles after the first edge with rst=0.
- Per frame, each unblanked digit is enabled for exactly DIV-BLANK_CYC consecutive cycles. Digits are enabled in order 0,1,…,DIGITS-1, separated by BLANK_CYC all-off cycles.
- Load-to-display latency: from 1 cycle (load on the frame-end cycle; the new nibble is visible from the next slot 0 output) up to DIGITS*DIV cycles.
- pending is high from the cycle after a non-frame-end load until the cycle after frame end.
- Reset mid-frame or mid-pending: all state returns to reset values on that edge. A pending value is discarded. load is ignored while rst=1.
- BLANK_CYC=0: no dead time; exactly one digit_en bit is low on every cycle after the first.

## Test plan
Parameters for all scenarios: DIGITS=4, DIV=4, BLANK_CYC=1.
- Reset and scan: release rst, no load → digit_en cycles 1111,1110×3,1111,1101×3,1111,1011×3,1111,0111×3, repeating every 16 cycles; nibble=0; blank=0; pending=0.
- Deferred load: after reset, load data=16'h1A3F mid-frame → pending=1 until frame end, disp unchanged until then. The next frame shows nibbles F,3,A,1 on digits 0..3; pending=0.
- Frame-end collision: hold pending (16'h1111), assert load with 16'h2222 on the frame-end cycle → next frame shows 2,2,2,2; pending=0 after that edge.
- Leading zeros: data=16'h0050, blank_lz=1 → digits 3 and 2 have digit_en all ones and blank=1; digits 1 and 0 show 5 and 0. Same data with blank_lz=0 → all four digits enabled.
- Zero value: data=16'h0000, blank_lz=1 → only digit 0 enabled (nibble 0); digits 1–3 blanked.
- Reset mid-pending: load 16'hBEEF, assert rst 3 cycles later → outputs return to reset values; after release, display shows 0000 and pending=0.
